stopwatch_ctrl_fsm: RTL
=======================

// Module: stopwatch_ctrl_fsm
// PURPOSE
//  Parametrised multi-channel stopwatch control. Each of N_CH independent channels
//  conditions two raw buttons: start/stop and lap/reset. It runs a 4-state FSM and
//  drives count enable, a counter clear pulse and a display freeze (lap hold).
//  Sits between board push-buttons and the per-channel BCD counters / 7-seg mux.
// PARAMETERS
//  N_CH       1  number of independent stopwatch channels (>=1)
//  DB_CYCLES  4  consecutive stable cycles needed to accept a level change (>=1)
//  LAP_EN     1  1: lap button freezes display while counting; 0: lap ignored in COUNT
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  btn_start   in   N_CH     raw asynchronous start/stop buttons, active-high
//  btn_lap     in   N_CH     raw asynchronous lap/reset buttons, active-high
//  count_en    out  N_CH     per-channel counter enable
//  clear       out  N_CH     one-cycle counter clear pulse
//  freeze      out  N_CH     hold the display value (lap view)
//  state       out  2*N_CH   per-channel state, channel i at [2i+1:2i]
//  any_running out  1        OR of count_en
// BEHAVIOUR
//  Conditioner (per button): 2-flop synchroniser, then debounce. The counter increments
//   each cycle the synced value != stable level. It clears on a match. When the count
//   reaches DB_CYCLES, the stable level flips and the counter clears. A rising edge of
//   the stable level gives a registered one-cycle pulse. Falling edges give no pulse.
//  A glitch shorter than DB_CYCLES cycles gives no pulse. Holding a button gives one pulse.
//  Latency: raw high before edge 1 -> count_en high after edge DB_CYCLES+4.
//  FSM per channel. States: IDLE=2'b00, COUNT=2'b01, LAP=2'b10, PAUSE=2'b11.
//   IDLE : start->COUNT; lap->IDLE, clear=1 for 1 cycle
//   COUNT: start->PAUSE; lap->LAP (LAP_EN=1) / ignored (LAP_EN=0)
//   LAP  : start->PAUSE; lap->COUNT
//   PAUSE: start->COUNT; lap->IDLE, clear=1 for 1 cycle
//  Start and lap pulses in the same cycle: start wins, lap is dropped.
//  Outputs are Moore, decoded from registered state:
//   count_en=1 in COUNT and LAP; freeze=1 in LAP only.
//  clear is a registered pulse, high the cycle after the lap-driven IDLE entry/stay.
//   It is never high for 2 consecutive cycles from a single press.
//  Reset (any time, including mid-debounce or in LAP):
//   - state=IDLE; count_en=0, clear=0, freeze=0, any_running=0.
//   - Synchronisers, stable levels and debounce counters go to 0; no pulse is generated.
//   - A button held through reset release is seen as a new press after DB_CYCLES.
//  Channels are fully independent; no cross-channel interaction except any_running.
//  Debounce counter width = $clog2(DB_CYCLES+1); no wrap (saturates by clearing).
// STRUCTURE
//  Shared header sw_ctrl_defs.vh: `define STATE_IDLE/COUNT/LAP/PAUSE 2-bit encodings.
//  Sub-module btn_conditioner (params DB_CYCLES; ports clk, rst, raw, pulse).
//   Instantiated 2*N_CH times via generate.
//  Top: generate loop of FSM regs + output decode, any_running reduction.
// TESTING
//  1 Reset: assert rst 3 cycles, buttons high -> all outputs 0, state=00, no pulse on release.
//  2 DB_CYCLES=4, btn_start[0] high 10 cycles:
//    count_en[0] rises after edge 8, stays; exactly one transition; state[1:0]=01.
//  3 Bounce: btn_start[0] high 3 cycles, low 1, high 3 -> no state change; then hold 4 -> COUNT.
//  4 Full cycle ch0: start, lap, lap, start, lap.
//    Expect COUNT, LAP (freeze=1, count_en=1), COUNT, PAUSE, IDLE.
//    clear[0] high exactly 1 cycle at the end.
//  5 Simultaneous: start and lap pressed the same cycle in COUNT -> PAUSE, freeze stays 0.
//  6 N_CH=3, LAP_EN=0: lap in COUNT on ch1 ignored.
//    Start on ch2 only -> count_en=3'b100, any_running=1.
//    rst in LAP mid-run -> all cleared.

Source files
------------

// File: rtl/stopwatch_ctrl_fsm_pkg.sv
// Shared types and helpers for the stopwatch control block.
//   sw_state_e     : per-channel FSM state, encoding is visible on the state port
//   is_running()   : state decodes to counter enable
//   is_frozen()    : state decodes to display hold
//   db_cnt_width() : width of the debounce counter for a given stable-cycle count
package stopwatch_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_LAP   = 2'b10,
        ST_PAUSE = 2'b11
    } sw_state_e;

    function automatic logic is_running(input sw_state_e s);
        return (s == ST_COUNT) || (s == ST_LAP);
    endfunction

    function automatic logic is_frozen(input sw_state_e s);
        return (s == ST_LAP);
    endfunction

    function automatic int db_cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_fsm_if.sv
// Button/status bundle between the board buttons and the stopwatch controller.
//   btn_start, btn_lap : raw per-channel buttons (driven by master)
//   count_en, clear,
//   freeze, state,
//   any_running        : per-channel controls and status (driven by slave)
// Channel i state is carried at state[2i+1:2i].
interface stopwatch_ctrl_fsm_if #(
    parameter int N_CH = 1
);
    logic [N_CH-1:0]   btn_start;
    logic [N_CH-1:0]   btn_lap;
    logic [N_CH-1:0]   count_en;
    logic [N_CH-1:0]   clear;
    logic [N_CH-1:0]   freeze;
    logic [2*N_CH-1:0] state;
    logic              any_running;

    modport master (
        output btn_start, btn_lap,
        input  count_en, clear, freeze, state, any_running
    );

    modport slave (
        input  btn_start, btn_lap,
        output count_en, clear, freeze, state, any_running
    );
endinterface

// File: rtl/stopwatch_ctrl_fsm_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce, rising-edge pulse.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears every flop (no pulse on release)
//   raw   : asynchronous button level, active-high
//   pulse : one-cycle registered pulse per accepted press
// The stable level flips once the synchronised input has disagreed with it for
// DB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_conditioner
    import stopwatch_ctrl_fsm_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q1  <= raw;
            sync_q2  <= sync_q1;
            stable_d <= stable;
            // stable_d catches up one cycle later, so the pulse is exactly one wide
            pulse    <= stable & ~stable_d;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // this cycle is the DB_CYCLES-th mismatch: accept the new level
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Multi-channel stopwatch controller.
//   clk : system clock, all logic on posedge
//   rst : synchronous active-high reset
//   sw  : slave side of stopwatch_ctrl_fsm_if (buttons in, controls/status out)
// Each channel conditions its start/stop and lap/reset buttons and runs an
// independent 4-state FSM. count_en and freeze are Moore decodes of the state
// register; clear is a registered pulse after a lap-driven IDLE entry or stay.
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | stopped, counter cleared or waiting to be cleared
// COUNT | counting, display live
// LAP   | counting, display frozen on the lap value
// PAUSE | stopped, display shows held count
module stopwatch_ctrl_fsm
    import stopwatch_ctrl_fsm_pkg::*;
#(
    parameter int N_CH      = 1,
    parameter int DB_CYCLES = 4,
    parameter int LAP_EN    = 1
) (
    input logic                 clk,
    input logic                 rst,
    stopwatch_ctrl_fsm_if.slave sw
);
    logic [N_CH-1:0]   start_p;
    logic [N_CH-1:0]   lap_p;
    logic [N_CH-1:0]   count_en_v;
    logic [N_CH-1:0]   clear_v;
    logic [N_CH-1:0]   freeze_v;
    logic [2*N_CH-1:0] state_v;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        sw_state_e st;
        logic      clear_q;

        btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw.btn_start[ch]),
            .pulse (start_p[ch])
        );

        btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_lap (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw.btn_lap[ch]),
            .pulse (lap_p[ch])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                st      <= ST_IDLE;
                clear_q <= 1'b0;
            end else begin
                clear_q <= 1'b0;
                // start has priority; a lap pulse in the same cycle is dropped
                if (start_p[ch]) begin
                    case (st)
                        ST_IDLE:  st <= ST_COUNT;
                        ST_COUNT: st <= ST_PAUSE;
                        ST_LAP:   st <= ST_PAUSE;
                        ST_PAUSE: st <= ST_COUNT;
                    endcase
                end else if (lap_p[ch]) begin
                    case (st)
                        ST_IDLE: begin
                            st      <= ST_IDLE;
                            clear_q <= 1'b1;
                        end
                        ST_COUNT: begin
                            if (LAP_EN != 0) begin
                                st <= ST_LAP;
                            end
                        end
                        ST_LAP:   st <= ST_COUNT;
                        ST_PAUSE: begin
                            st      <= ST_IDLE;
                            clear_q <= 1'b1;
                        end
                    endcase
                end
            end
        end

        assign state_v[2*ch +: 2] = st;
        assign count_en_v[ch]     = is_running(st);
        assign freeze_v[ch]       = is_frozen(st);
        assign clear_v[ch]        = clear_q;
    end

    assign sw.state       = state_v;
    assign sw.count_en    = count_en_v;
    assign sw.freeze      = freeze_v;
    assign sw.clear       = clear_v;
    assign sw.any_running = |count_en_v;
endmodule
